text_renderer: RTL and testbench
================================

TEXT_RENDERER -- requirements
Module: text_renderer

Interface
REQ-001 SHALL have parameter COLS, default 32: text columns per screen.
REQ-002 SHALL have parameter ROWS, default 30: text rows per screen.
REQ-003 SHALL have parameter GLYPH_W, default 8: glyph width in pixels; glyph_bits width.
REQ-004 SHALL have parameter GLYPH_H, default 8: glyph height in scanlines.
REQ-005 SHALL have parameter CHAR_BITS, default 6: character code width.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1: frame-start pulse.
REQ-009 SHALL have port txt_rd, output, 1: text RAM read strobe.
REQ-010 SHALL have port txt_addr, output, clog2(COLS*ROWS): text RAM address, row*COLS+col.
REQ-011 SHALL have port txt_data, input, CHAR_BITS: text RAM data, valid the cycle after txt_rd.
REQ-012 SHALL have port glyph_char, output, CHAR_BITS: code to the combinational glyph ROM.
REQ-013 SHALL have port glyph_row, output, clog2(GLYPH_H): glyph scanline index to the ROM.
REQ-014 SHALL have port glyph_bits, input, GLYPH_W: ROM row, MSB = leftmost pixel, same-cycle response.
REQ-015 SHALL have ports pix_valid (output, 1), pix_ready (input, 1), pix_on (output, 1): pixel stream.
REQ-016 SHALL have ports pix_eol, pix_eof, busy (output, 1 each): end of scanline, end of frame, frame in progress.

Function
REQ-017 SHALL use states IDLE, FETCH, LOAD, SHIFT.
REQ-018 IDLE: start=1 -> FETCH with scanline y=0, column 0; busy=1 from the next cycle.
REQ-019 FETCH (1 cycle): txt_rd=1, txt_addr=(y/GLYPH_H)*COLS+col; -> LOAD.
REQ-020 LOAD (1 cycle): glyph_char=txt_data, glyph_row=y%GLYPH_H; glyph_bits captured into a GLYPH_W shift register; -> SHIFT.
REQ-021 Codes above 38 SHALL be replaced by 38 (space) on glyph_char.
REQ-022 SHIFT: pix_valid=1, pix_on=current MSB; each cycle with pix_valid&pix_ready shifts left by one.
REQ-023 With pix_ready=0, pix_on, pix_eol and pix_eof SHALL hold stable; no pixel dropped or duplicated.
REQ-024 After the GLYPH_W-th accepted pixel of a cell: col+1 -> FETCH; after the last column: col=0, y+1 -> FETCH.
REQ-025 pix_eol SHALL be 1 with the last pixel of each scanline; pix_eof with the last pixel of scanline ROWS*GLYPH_H-1.
REQ-026 Acceptance of the pix_eof pixel -> IDLE; busy=0 the next cycle.
REQ-027 Latency: start sampled at cycle 0; txt_rd at cycle 1; first pix_valid at cycle 3.
REQ-028 Each cell SHALL be refetched on every scanline; per-cell overhead is 2 cycles (FETCH, LOAD).
REQ-029 start while busy=1 SHALL be ignored; start with the final acceptance SHALL also be ignored.
REQ-030 txt_rd SHALL be 1 only in FETCH; pix_valid SHALL be 1 only in SHIFT.

Reset
REQ-031 rst_n=0 SHALL force IDLE immediately, including mid-frame.
REQ-032 rst_n=0 SHALL clear counters, shift register, txt_rd, pix_valid, pix_on, pix_eol, pix_eof, busy, txt_addr, glyph_char and glyph_row to 0.
REQ-033 After release, no output SHALL change until start=1.

Configuration
REQ-034 With TXT_CURSOR_EN defined, SHALL add inputs cursor_col (clog2(COLS)), cursor_row (clog2(ROWS)) and cursor_en (1).
REQ-035 With TXT_CURSOR_EN defined and cursor_en=1, pixels of the cell at (cursor_row, cursor_col) SHALL be inverted on pix_on.
REQ-036 Without TXT_CURSOR_EN, the cursor ports and inversion logic SHALL be absent; pix_on = glyph bit.

Verification
REQ-037 Defaults, pix_ready=1, all text=1, pulse start -> txt_rd at cycle 1; first pixels 0,0,0,1,1,0,0,0 from cycle 3; 32*30*8*8 pixels; one pix_eof.
REQ-038 Cell (0,0)=10 ('A'), scanline 4 -> row index 4, pixels 1,1,1,1,1,1,1,0.
REQ-039 Random pix_ready stalls -> stream identical to the pix_ready=1 stream; outputs stable while stalled.
REQ-040 Code 63 in a cell -> glyph_char=38 during its LOAD.
REQ-041 rst_n low mid-SHIFT -> pix_valid=0 and busy=0 at once; start mid-frame ignored.
REQ-042 TXT_CURSOR_EN, cursor (0,0), cursor_en=1, code 0 -> row 0 pixels 1,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/text_renderer.sv
// -----------------------------------------------------------------------------
// text_renderer
//   Renders a text screen (COLS x ROWS character cells) into a serial pixel
//   stream. Each scanline refetches every cell from text RAM, looks up the
//   glyph row in an external combinational ROM, and shifts it out MSB first
//   under a valid/ready handshake.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 frame-start pulse (honoured only when idle)
//   txt_rd, txt_addr      text RAM read strobe / address (row*COLS+col)
//   txt_data              text RAM data, valid the cycle after txt_rd
//   glyph_char, glyph_row glyph ROM lookup (code, scanline within glyph)
//   glyph_bits            ROM row, MSB = leftmost pixel, same-cycle
//   pix_valid/ready/on    pixel stream
//   pix_eol, pix_eof      last pixel of scanline / of frame
//   busy                  frame in progress
//
// Optional build macro
//   TXT_CURSOR_EN         adds cursor_col/cursor_row/cursor_en inputs; the
//                         cursor cell is rendered inverted.
// -----------------------------------------------------------------------------
module text_renderer #(
    parameter int COLS      = 32,
    parameter int ROWS      = 30,
    parameter int GLYPH_W   = 8,
    parameter int GLYPH_H   = 8,
    parameter int CHAR_BITS = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            txt_rd,
    output logic [$clog2(COLS*ROWS)-1:0]    txt_addr,
    input  logic [CHAR_BITS-1:0]            txt_data,
    output logic [CHAR_BITS-1:0]            glyph_char,
    output logic [$clog2(GLYPH_H)-1:0]      glyph_row,
    input  logic [GLYPH_W-1:0]              glyph_bits,
`ifdef TXT_CURSOR_EN
    input  logic [$clog2(COLS)-1:0]         cursor_col,
    input  logic [$clog2(ROWS)-1:0]         cursor_row,
    input  logic                            cursor_en,
`endif
    output logic                            pix_valid,
    input  logic                            pix_ready,
    output logic                            pix_on,
    output logic                            pix_eol,
    output logic                            pix_eof,
    output logic                            busy
);
    localparam int AW = $clog2(COLS*ROWS);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(GLYPH_H);
    localparam int BW = $clog2(GLYPH_W);
    localparam int SPACE = 38;

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        trow_q, trow_d;   // text row (y / GLYPH_H)
    logic [SW-1:0]        scan_q, scan_d;   // scanline inside glyph (y % GLYPH_H)
    logic [BW-1:0]        bit_q, bit_d;     // pixels of current cell accepted
    logic [GLYPH_W-1:0]   sh_q, sh_d;

    logic accept, last_bit, last_col, last_scan, last_trow;

    assign accept    = (state_q == SHIFT) && pix_ready;
    assign last_bit  = (bit_q == BW'(GLYPH_W-1));
    assign last_col  = (col_q == CW'(COLS-1));
    assign last_scan = (scan_q == SW'(GLYPH_H-1));
    assign last_trow = (trow_q == RW'(ROWS-1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            trow_q  <= '0;
            scan_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            trow_q  <= trow_d;
            scan_q  <= scan_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = FETCH;
            FETCH: state_d = LOAD;
            LOAD:  state_d = SHIFT;
            SHIFT: if (accept && last_bit)
                       state_d = (last_col && last_scan && last_trow) ? IDLE : FETCH;
        endcase
    end

    // Counters and shift register. All counters wrap to zero on the final
    // pixel, so the block is back in its reset condition when it goes idle.
    always_comb begin
        col_d  = col_q;
        trow_d = trow_q;
        scan_d = scan_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        if (state_q == LOAD) begin
            sh_d  = glyph_bits;
            bit_d = '0;
        end
        if (accept) begin
            sh_d  = {sh_q[GLYPH_W-2:0], 1'b0};
            bit_d = bit_q + 1'b1;
            if (last_bit) begin
                bit_d = '0;
                if (last_col) begin
                    col_d = '0;
                    if (last_scan) begin
                        scan_d = '0;
                        trow_d = last_trow ? '0 : trow_q + 1'b1;
                    end else begin
                        scan_d = scan_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    // Outputs: everything is gated by state so idle outputs stay at zero
    // regardless of what the RAM/ROM inputs are doing.
    always_comb begin
        txt_rd     = 1'b0;
        txt_addr   = '0;
        glyph_char = '0;
        glyph_row  = '0;
        pix_valid  = 1'b0;
        pix_on     = 1'b0;
        pix_eol    = 1'b0;
        pix_eof    = 1'b0;
        busy       = (state_q != IDLE);
        unique case (state_q)
            IDLE: ;
            FETCH: begin
                txt_rd   = 1'b1;
                txt_addr = AW'(int'(trow_q) * COLS + int'(col_q));
            end
            LOAD: begin
                // Codes beyond the glyph set render as space
                glyph_char = (int'(txt_data) > SPACE) ? CHAR_BITS'(SPACE) : txt_data;
                glyph_row  = scan_q;
            end
            SHIFT: begin
                pix_valid = 1'b1;
`ifdef TXT_CURSOR_EN
                pix_on = sh_q[GLYPH_W-1] ^
                         (cursor_en && (col_q == cursor_col) && (trow_q == cursor_row));
`else
                pix_on = sh_q[GLYPH_W-1];
`endif
                pix_eol = last_bit && last_col;
                pix_eof = last_bit && last_col && last_scan && last_trow;
            end
        endcase
    end
endmodule

// File: tb/tb_text_renderer.sv
// Bench for text_renderer on a reduced 5x3 screen. A frame-level model
// expands text memory through the glyph ROM into the expected fetch and
// pixel sequences; a per-cycle compare process checks the DUT against it.
module tb_text_renderer;
    localparam int COLS  = 5;
    localparam int ROWS  = 3;
    localparam int GW    = 8;
    localparam int GH    = 8;
    localparam int CB    = 6;
    localparam int NCELL = COLS * ROWS;
    localparam int NPIX  = NCELL * GW * GH;
    localparam int LASTY = ROWS * GH - 1;
    localparam int AW    = $clog2(NCELL);

    // Glyph ROM contents: '0', '1', 'A'; other codes get filler patterns.
    localparam logic [63:0] G0 = 64'h7CC6CED6E6C67C00;
    localparam logic [63:0] G1 = 64'h183818181818_7E00;
    localparam logic [63:0] GA = 64'h183C6666FEC6C600;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pix_ready = 1'b1;
    logic txt_rd;
    logic [AW-1:0] txt_addr;
    logic [CB-1:0] txt_data = '0;
    logic [CB-1:0] glyph_char;
    logic [2:0]    glyph_row;
    logic [GW-1:0] glyph_bits;
    logic pix_valid, pix_on, pix_eol, pix_eof, busy;
`ifdef TXT_CURSOR_EN
    logic [$clog2(COLS)-1:0] cursor_col = '0;
    logic [$clog2(ROWS)-1:0] cursor_row = '0;
    logic cursor_en = 1'b0;
`endif

    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    text_renderer #(.COLS(COLS), .ROWS(ROWS), .GLYPH_W(GW), .GLYPH_H(GH), .CHAR_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .txt_rd(txt_rd), .txt_addr(txt_addr), .txt_data(txt_data),
        .glyph_char(glyph_char), .glyph_row(glyph_row), .glyph_bits(glyph_bits),
`ifdef TXT_CURSOR_EN
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
`endif
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_on(pix_on),
        .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy)
    );

    function automatic logic [7:0] rom(input logic [5:0] c, input logic [2:0] r);
        logic [63:0] g;
        if (c == 6'd0)       g = G0;
        else if (c == 6'd1)  g = G1;
        else if (c == 6'd10) g = GA;
        else if (c == 6'd38) g = 64'h0;
        else                 g = 64'h9E3779B97F4A7C15 * (64'(c) + 64'd1);
        return g[63 - 8*int'(r) -: 8];
    endfunction

    assign glyph_bits = rom(glyph_char, glyph_row);

    logic [CB-1:0] mem [NCELL];
    always @(posedge clk) if (txt_rd) txt_data <= mem[txt_addr];

    typedef struct packed { logic on; logic eol; logic eof; } pix_t;
    typedef struct { int addr; int code; int scan; } fet_t;
    pix_t exp_q[$];
    fet_t fet_q[$];
    fet_t cur_fet;
    logic dut_pix [NPIX];
    int   npix, eof_cnt, gc_cell1;
    bit   chk_en = 0, stall = 0, load_pend = 0, eof_acc = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-frame expected behaviour straight from the screen definition.
    task automatic start_frame();
        exp_q.delete();
        fet_q.delete();
        for (int y = 0; y <= LASTY; y++)
            for (int c = 0; c < COLS; c++) begin
                int a, code;
                logic [7:0] bits;
                a    = (y / GH) * COLS + c;
                code = (int'(mem[a]) > 38) ? 38 : int'(mem[a]);
                fet_q.push_back('{a, code, y % GH});
                bits = rom(6'(code), 3'(y % GH));
`ifdef TXT_CURSOR_EN
                if (cursor_en && c == int'(cursor_col) && (y / GH) == int'(cursor_row))
                    bits = ~bits;
`endif
                for (int b = 0; b < GW; b++)
                    exp_q.push_back('{bits[GW-1-b], (c == COLS-1) && (b == GW-1),
                                      (c == COLS-1) && (b == GW-1) && (y == LASTY)});
            end
        npix = 0; eof_cnt = 0; gc_cell1 = -1; load_pend = 0; eof_acc = 0;
        chk_en = 1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({name, "_done"}, int'(busy), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    function automatic int first8(input int base);
        int v = 0;
        for (int i = 0; i < 8; i++) v = (v << 1) | int'(dut_pix[base + i]);
        return v;
    endfunction

    task automatic check_idle_outputs(input string name);
        check(name, int'({txt_rd, txt_addr, glyph_char, glyph_row, pix_valid,
                          pix_on, pix_eol, pix_eof, busy}), 0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                pix_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (chk_en) begin
                    if (eof_acc) begin
                        check("busy_after_eof", int'(busy), 0);
                        eof_acc = 0;
                    end
                    if (load_pend) begin
                        check("glyph_char", int'(glyph_char), cur_fet.code);
                        check("glyph_row", int'(glyph_row), cur_fet.scan);
                        if (cur_fet.addr == 1 && gc_cell1 < 0) gc_cell1 = int'(glyph_char);
                        load_pend = 0;
                    end
                    if (txt_rd) begin
                        if (fet_q.size() == 0) check("txt_rd_unexpected", 1, 0);
                        else begin
                            cur_fet = fet_q.pop_front();
                            check("txt_addr", int'(txt_addr), cur_fet.addr);
                            load_pend = 1;
                        end
                    end
                    if (pix_valid) begin
                        if (exp_q.size() == 0) check("pix_valid_unexpected", 1, 0);
                        else begin
                            check("pixel{on,eol,eof}", int'({pix_on, pix_eol, pix_eof}), int'(exp_q[0]));
                            if (pix_ready) begin
                                void'(exp_q.pop_front());
                                if (npix < NPIX) dut_pix[npix] = pix_on;
                                npix++;
                                if (pix_eof) begin eof_cnt++; eof_acc = 1; end
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state and quiet period after release
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_outputs");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_idle_outputs("post_release_quiet");

        // Frame A: all cells code 1, no stalls, latency pinned
        for (int i = 0; i < NCELL; i++) mem[i] = 6'd1;
        start_frame();
        pulse_start();
        check("lat_txt_rd_c1", int'(txt_rd), 1);
        check("lat_busy_c1", int'(busy), 1);
        @(posedge clk); #1;
        check("lat_valid_c2", int'(pix_valid), 0);
        @(posedge clk); #1;
        check("lat_valid_c3", int'(pix_valid), 1);
        wait_idle("frameA");
        check("frameA_npix", npix, NPIX);
        check("frameA_eof", eof_cnt, 1);
        check("frameA_first8", first8(0), 8'b00011000);
        check("frameA_left", exp_q.size(), 0);

        // Frame B: mixed codes, random stalls, start pulse mid-frame
        for (int i = 0; i < NCELL; i++) mem[i] = 6'($urandom_range(0, 63));
        mem[0] = 6'd10;
        mem[1] = 6'd63;
        stall = 1;
        start_frame();
        pulse_start();
        repeat (100) @(negedge clk);
        pulse_start();
        wait_idle("frameB");
        stall = 0;
        check("frameB_npix", npix, NPIX);
        check("frameB_eof", eof_cnt, 1);
        check("frameB_A_scan4", first8(4 * COLS * GW), 8'b11111110);
        check("frameB_code63", gc_cell1, 38);

        // Frame C: same text, no stalls, start held on the final acceptance
        start_frame();
        pulse_start();
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (pix_eof) break;
        end
        check("frameC_saw_eof", int'(pix_eof), 1);
        pulse_start();
        repeat (5) @(negedge clk);
        check("frameC_no_restart", int'(busy), 0);
        check("frameC_npix", npix, NPIX);

        // Frame D: reset mid-SHIFT
        start_frame();
        pulse_start();
        repeat (50) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (pix_valid) break;
            @(negedge clk);
        end
        check("frameD_in_shift", int'(pix_valid), 1);
        chk_en = 0;
        rst_n = 1'b0;
        #1;
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_busy", int'(busy), 0);
        check_idle_outputs("rst_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_idle_outputs("rst_release_quiet");

`ifdef TXT_CURSOR_EN
        // Cursor on cell (0,0) over code 0
        for (int i = 0; i < NCELL; i++) mem[i] = 6'd0;
        cursor_en = 1'b1;
        start_frame();
        pulse_start();
        wait_idle("cursor");
        check("cursor_first8", first8(0), 8'b10000011);
        cursor_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
